monitor_vitais: RTL and testbench

Tracks the pet's vital meters (hunger, sleepiness, boredom) and reports death back to the state controller. It consumes the controller's 3-bit `estado` and returns the `morreu` flag that forces the controller into MORTO. Meters are updated once per prescaled time tick according to the current activity. It sits between the state controller and the display/LED logic, which read the meter levels and the alert flag.

---
 rtl/monitor_vitais.sv | 143 ++++++++++++++
 tb/tb_monitor_vitais.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_vitais.sv
// monitor_vitais: tracks the pet's vital meters (fome, sono, tedio) on a
// prescaled time tick according to the controller's current activity, flags
// an alert level and raises a sticky death flag back to the controller.
// Optional feature macro: MONITOR_VITAIS_TEDIO_EN builds the boredom meter;
// when undefined, tedio is tied to 0 and ignored by alerta and death.
module monitor_vitais #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned ALERTA_NIVEL = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] estado,
  output logic [3:0] fome,
  output logic [3:0] sono,
  output logic [3:0] tedio,
  output logic       alerta,
  output logic       morreu
);

  localparam int unsigned MW = 4;
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [MW-1:0] M_MAX    = '1;
  localparam logic [MW-1:0] M_ALERTA = MW'(ALERTA_NIVEL);

  // Controller state encodings; anything not listed behaves as IDLE.
  localparam logic [2:0] ST_DORMINDO = 3'b001;
  localparam logic [2:0] ST_COMENDO  = 3'b010;
  localparam logic [2:0] ST_AULA     = 3'b011;
  localparam logic [2:0] ST_MORTO    = 3'b100;

  logic [CW-1:0] cnt;
  logic          tick;
  logic          upd;
  logic          any_max;
  logic [MW-1:0] fome_d;
  logic [MW-1:0] sono_d;

  function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
    return (v == M_MAX) ? v : v + MW'(1);
  endfunction

  function automatic logic [MW-1:0] sat_dec2(input logic [MW-1:0] v);
    return (v < MW'(2)) ? '0 : v - MW'(2);
  endfunction

  // Free-running prescaler, wraps after TICK_DIV cycles in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);
  // A dead pet's meters are frozen regardless of estado.
  assign upd  = tick && !morreu;

  // Next values for hunger and sleepiness from the activity sampled this cycle.
  always_comb begin
    fome_d = fome;
    sono_d = sono;
    if (upd) begin
      case (estado)
        ST_DORMINDO: begin
          fome_d = sat_inc(fome);
          sono_d = sat_dec2(sono);
        end
        ST_COMENDO: begin
          fome_d = sat_dec2(fome);
          sono_d = sat_inc(sono);
        end
        ST_AULA: begin
          fome_d = sat_inc(fome);
          sono_d = sat_inc(sono);
        end
        ST_MORTO: begin
        end
        default: begin
          fome_d = sat_inc(fome);
          sono_d = sat_inc(sono);
        end
      endcase
    end
  end

  // Hunger and sleepiness registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fome <= '0;
      sono <= '0;
    end else begin
      fome <= fome_d;
      sono <= sono_d;
    end
  end

`ifdef MONITOR_VITAIS_TEDIO_EN
  logic [MW-1:0] tedio_d;

  // Next boredom value: teaching relieves it, sleep and death leave it alone.
  always_comb begin
    tedio_d = tedio;
    if (upd) begin
      case (estado)
        ST_DORMINDO: tedio_d = tedio;
        ST_MORTO:    tedio_d = tedio;
        ST_AULA:     tedio_d = sat_dec2(tedio);
        default:     tedio_d = sat_inc(tedio);
      endcase
    end
  end

  // Boredom register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tedio <= '0;
    end else begin
      tedio <= tedio_d;
    end
  end

  assign any_max = (fome == M_MAX) || (sono == M_MAX) || (tedio == M_MAX);
  assign alerta  = (fome >= M_ALERTA) || (sono >= M_ALERTA) || (tedio >= M_ALERTA);
`else
  assign tedio   = '0;
  assign any_max = (fome == M_MAX) || (sono == M_MAX);
  assign alerta  = (fome >= M_ALERTA) || (sono >= M_ALERTA);
`endif

  // Sticky death flag, set one cycle after any live meter reads full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      morreu <= 1'b0;
    end else if (!morreu && any_max) begin
      morreu <= 1'b1;
    end
  end

endmodule

// File: tb/tb_monitor_vitais.sv
// tb_monitor_vitais: directed scenarios plus randomized estado sequences
// compared against an arithmetic model of the meter rules.
module tb_monitor_vitais;

  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned ALERTA_NIVEL = 12;
`ifdef MONITOR_VITAIS_TEDIO_EN
  localparam bit TEDIO_EN = 1'b1;
`else
  localparam bit TEDIO_EN = 1'b0;
`endif

  localparam logic [2:0] IDLE  = 3'b000;
  localparam logic [2:0] DORM  = 3'b001;
  localparam logic [2:0] COME  = 3'b010;
  localparam logic [2:0] AULA  = 3'b011;
  localparam logic [2:0] MORTO = 3'b100;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [2:0] estado = 3'b000;
  logic [3:0] fome;
  logic [3:0] sono;
  logic [3:0] tedio;
  logic       alerta;
  logic       morreu;

  int checks   = 0;
  int failures = 0;

  // Reference model state: meter values, death flag, cycles since last tick.
  int mf, ms, mt, ph;
  bit md;

  monitor_vitais #(
    .TICK_DIV    (TICK_DIV),
    .ALERTA_NIVEL(ALERTA_NIVEL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .estado(estado),
    .fome  (fome),
    .sono  (sono),
    .tedio (tedio),
    .alerta(alerta),
    .morreu(morreu)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int up(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  function automatic int dn(input int v);
    return (v < 2) ? 0 : v - 2;
  endfunction

  function automatic bit m_alerta();
    return (mf >= ALERTA_NIVEL) || (ms >= ALERTA_NIVEL) ||
           (TEDIO_EN && (mt >= ALERTA_NIVEL));
  endfunction

  function automatic int exp_t(input int v);
    return TEDIO_EN ? v : 0;
  endfunction

  task automatic model_reset();
    mf = 0; ms = 0; mt = 0; md = 1'b0; ph = 0;
  endtask

  // One clock with estado e applied; the model follows the activity rules.
  task automatic cyc(input logic [2:0] e);
    bit tk;
    bit dead_n;
    estado = e;
    @(posedge clk);
    tk     = (ph == TICK_DIV - 1);
    dead_n = md || (mf == 15) || (ms == 15) || (TEDIO_EN && (mt == 15));
    if (tk && !md) begin
      case (e)
        DORM:    begin mf = up(mf); ms = dn(ms); end
        COME:    begin mf = dn(mf); ms = up(ms); mt = up(mt); end
        AULA:    begin mf = up(mf); ms = up(ms); mt = dn(mt); end
        MORTO:   begin end
        default: begin mf = up(mf); ms = up(ms); mt = up(mt); end
      endcase
      if (!TEDIO_EN) mt = 0;
    end
    md = dead_n;
    ph = tk ? 0 : ph + 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    estado = IDLE;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (fome !== 4'd0)  begin failures++; $display("FAIL reset_fome got=%0d exp=0", fome); end
    checks++; if (sono !== 4'd0)  begin failures++; $display("FAIL reset_sono got=%0d exp=0", sono); end
    checks++; if (tedio !== 4'd0) begin failures++; $display("FAIL reset_tedio got=%0d exp=0", tedio); end
    checks++; if (alerta !== 1'b0) begin failures++; $display("FAIL reset_alerta got=%b exp=0", alerta); end
    checks++; if (morreu !== 1'b0) begin failures++; $display("FAIL reset_morreu got=%b exp=0", morreu); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_death();
    do_reset();
    repeat (47) cyc(IDLE);
    checks++; if (fome !== 4'd11) begin failures++; $display("FAIL idle_t11_fome got=%0d exp=11", fome); end
    checks++; if (alerta !== 1'b0) begin failures++; $display("FAIL idle_t11_alerta got=%b exp=0", alerta); end
    cyc(IDLE);
    checks++; if (fome !== 4'd12) begin failures++; $display("FAIL idle_t12_fome got=%0d exp=12", fome); end
    checks++; if (sono !== 4'd12) begin failures++; $display("FAIL idle_t12_sono got=%0d exp=12", sono); end
    checks++; if (tedio !== 4'(exp_t(12))) begin failures++; $display("FAIL idle_t12_tedio got=%0d exp=%0d", tedio, exp_t(12)); end
    checks++; if (alerta !== 1'b1) begin failures++; $display("FAIL idle_t12_alerta got=%b exp=1", alerta); end
    repeat (12) cyc(IDLE);
    checks++; if (fome !== 4'd15) begin failures++; $display("FAIL idle_t15_fome got=%0d exp=15", fome); end
    checks++; if (sono !== 4'd15) begin failures++; $display("FAIL idle_t15_sono got=%0d exp=15", sono); end
    checks++; if (tedio !== 4'(exp_t(15))) begin failures++; $display("FAIL idle_t15_tedio got=%0d exp=%0d", tedio, exp_t(15)); end
    checks++; if (morreu !== 1'b0) begin failures++; $display("FAIL idle_t15_morreu_early got=%b exp=0", morreu); end
    cyc(IDLE);
    checks++; if (morreu !== 1'b1) begin failures++; $display("FAIL idle_death_latency got=%b exp=1", morreu); end
  endtask

  // Continues from the dead pet left by test_idle_death.
  task automatic test_death_freeze();
    for (int i = 0; i < 20; i++) begin
      cyc(IDLE);
      checks++;
      if (fome !== 4'd15 || sono !== 4'd15 || morreu !== 1'b1) begin
        failures++;
        $display("FAIL dead_freeze cyc=%0d got fome=%0d sono=%0d morreu=%b exp 15 15 1", i, fome, sono, morreu);
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (fome !== 4'd0 || sono !== 4'd0 || tedio !== 4'd0) begin failures++; $display("FAIL async_rst_meters got=%0d %0d %0d exp=0 0 0", fome, sono, tedio); end
    checks++; if (alerta !== 1'b0 || morreu !== 1'b0) begin failures++; $display("FAIL async_rst_flags got alerta=%b morreu=%b exp=0 0", alerta, morreu); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(IDLE);
    checks++; if (fome !== 4'd0) begin failures++; $display("FAIL first_tick_early got=%0d exp=0", fome); end
    cyc(IDLE);
    checks++; if (fome !== 4'd1) begin failures++; $display("FAIL first_tick got=%0d exp=1", fome); end
  endtask

  task automatic test_comendo();
    int exp_f [3];
    exp_f[0] = 1; exp_f[1] = 0; exp_f[2] = 0;
    do_reset();
    repeat (12) cyc(IDLE);
    checks++; if (fome !== 4'd3) begin failures++; $display("FAIL comendo_start got=%0d exp=3", fome); end
    for (int k = 0; k < 3; k++) begin
      repeat (4) cyc(COME);
      checks++; if (fome !== 4'(exp_f[k])) begin failures++; $display("FAIL comendo_fome t=%0d got=%0d exp=%0d", k + 1, fome, exp_f[k]); end
      checks++; if (sono !== 4'(4 + k)) begin failures++; $display("FAIL comendo_sono t=%0d got=%0d exp=%0d", k + 1, sono, 4 + k); end
      checks++; if (tedio !== 4'(exp_t(4 + k))) begin failures++; $display("FAIL comendo_tedio t=%0d got=%0d exp=%0d", k + 1, tedio, exp_t(4 + k)); end
    end
  endtask

  // Reach fome=2 sono=10 tedio=7 using clamped eating, idle and teaching.
  task automatic test_dormindo();
    do_reset();
    repeat (32) cyc(COME);
    repeat (4) cyc(IDLE);
    repeat (4) cyc(AULA);
    checks++; if (fome !== 4'd2 || sono !== 4'd10 || tedio !== 4'(exp_t(7))) begin
      failures++; $display("FAIL dorm_setup got=%0d %0d %0d exp=2 10 %0d", fome, sono, tedio, exp_t(7));
    end
    repeat (4) cyc(DORM);
    checks++; if (fome !== 4'd3) begin failures++; $display("FAIL dorm_fome got=%0d exp=3", fome); end
    checks++; if (sono !== 4'd8) begin failures++; $display("FAIL dorm_sono got=%0d exp=8", sono); end
    checks++; if (tedio !== 4'(exp_t(7))) begin failures++; $display("FAIL dorm_tedio got=%0d exp=%0d", tedio, exp_t(7)); end
  endtask

  task automatic test_invalid_estado();
    do_reset();
    repeat (12) cyc(3'b110);
    checks++; if (fome !== 4'd3 || sono !== 4'd3 || tedio !== 4'(exp_t(3))) begin
      failures++; $display("FAIL estado110 got=%0d %0d %0d exp=3 3 %0d", fome, sono, tedio, exp_t(3));
    end
    repeat (8) cyc(3'($urandom_range(5, 7)));
    checks++; if (fome !== 4'd5 || sono !== 4'd5) begin failures++; $display("FAIL estado_hi got=%0d %0d exp=5 5", fome, sono); end
  endtask

  task automatic test_aula_death();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      cyc(AULA);
      checks++; if (tedio !== 4'd0) begin failures++; $display("FAIL aula_tedio cyc=%0d got=%0d exp=0", i, tedio); end
    end
    checks++; if (fome !== 4'd15 || sono !== 4'd15 || morreu !== 1'b0) begin
      failures++; $display("FAIL aula_t15 got=%0d %0d morreu=%b exp=15 15 0", fome, sono, morreu);
    end
    cyc(AULA);
    checks++; if (morreu !== 1'b1) begin failures++; $display("FAIL aula_death got=%b exp=1", morreu); end
  endtask

  // Random estado runs of random length, every cycle against the model.
  task automatic test_random();
    logic [2:0] e;
    int len;
    do_reset();
    for (int s = 0; s < 120; s++) begin
      e   = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 12);
      if (md && ($urandom_range(0, 2) == 0)) do_reset();
      for (int c = 0; c < len; c++) begin
        cyc(e);
        checks++; if (fome !== 4'(mf)) begin failures++; $display("FAIL rnd_fome s=%0d got=%0d exp=%0d", s, fome, mf); end
        checks++; if (sono !== 4'(ms)) begin failures++; $display("FAIL rnd_sono s=%0d got=%0d exp=%0d", s, sono, ms); end
        checks++; if (tedio !== 4'(mt)) begin failures++; $display("FAIL rnd_tedio s=%0d got=%0d exp=%0d", s, tedio, mt); end
        checks++; if (alerta !== m_alerta()) begin failures++; $display("FAIL rnd_alerta s=%0d got=%b exp=%b", s, alerta, m_alerta()); end
        checks++; if (morreu !== md) begin failures++; $display("FAIL rnd_morreu s=%0d got=%b exp=%b", s, morreu, md); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_death();
    test_death_freeze();
    test_comendo();
    test_dormindo();
    test_invalid_estado();
    test_aula_death();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
